// File: rtl/cell_update_serial.sv
// cell_update_serial: serial Game-of-Life cell evaluator.
// Takes 8 neighbour bits and then the cell's own bit, one bit per valid/ready
// beat. It counts live neighbours and then holds the next-generation state on
// a valid/ready output channel until the downstream side takes it.
// Optional feature macro: CELL_UPDATE_COUNT_OUT_EN adds the OUT_COUNT port,
// which carries the final live-neighbour count.
module cell_update_serial (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic       IN_BIT,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic       OUT_ALIVE
`ifdef CELL_UPDATE_COUNT_OUT_EN
    ,
    output logic [3:0] OUT_COUNT
`endif
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t     r_state;
    logic [3:0] r_beat;       // beat index, 0..8
    logic [3:0] r_cnt;        // live-neighbour count, 0..8, cannot overflow
    logic       r_in_ready;
    logic       r_out_valid;
    logic       r_out_alive;
`ifdef CELL_UPDATE_COUNT_OUT_EN
    logic [3:0] r_count_out;
`endif

    logic       w_accept;
    logic       w_next_alive;

    // A beat is taken only while the registered ready is high, so IN_VALID
    // never reaches OUT_VALID through combinational logic.
    assign w_accept     = IN_VALID && r_in_ready;
    // The own-cell bit arrives on beat 8. It goes straight into the survival
    // term here, so no separate register is needed for it.
    assign w_next_alive = (r_cnt == 4'd3) | (IN_BIT & (r_cnt == 4'd2));

    // Handshake FSM, accumulator and registered outputs in a single process.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            // NOTE: the reset clears every register, datapath included, so a
            // cell that was only partly counted leaves nothing behind.
            r_state     <= ACCUM;
            r_beat      <= 4'd0;
            r_cnt       <= 4'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_alive <= 1'b0;
`ifdef CELL_UPDATE_COUNT_OUT_EN
            r_count_out <= 4'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments here. Every branch reads the
            // values from before the edge, so r_cnt in w_next_alive is the
            // final count and does not include the beat being accepted.
            case (r_state)
                ACCUM: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    if (w_accept) begin
                        if (r_beat != 4'd8) begin
                            r_cnt  <= r_cnt + {3'b000, IN_BIT};
                            r_beat <= r_beat + 4'd1;
                        end else begin
                            r_out_alive <= w_next_alive;
`ifdef CELL_UPDATE_COUNT_OUT_EN
                            r_count_out <= r_cnt;
`endif
                            r_beat      <= 4'd0;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (OUT_READY) begin
                        r_cnt       <= 4'd0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_state     <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_out_valid;
    assign OUT_ALIVE = r_out_alive;
`ifdef CELL_UPDATE_COUNT_OUT_EN
    assign OUT_COUNT = r_count_out;
`endif

endmodule

// File: tb/tb_cell_update_serial.sv
// Directed testbench for cell_update_serial. Inputs change on the falling
// edge and outputs are sampled there, half a clock away from the active edge.
// With CELL_UPDATE_COUNT_OUT_EN defined, OUT_COUNT is checked as well.
module tb_cell_update_serial;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       IN_VALID;
    logic       IN_READY;
    logic       IN_BIT;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic       OUT_ALIVE;
`ifdef CELL_UPDATE_COUNT_OUT_EN
    logic [3:0] OUT_COUNT;
`endif

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int start;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    cell_update_serial dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_BIT    (IN_BIT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_ALIVE (OUT_ALIVE)
`ifdef CELL_UPDATE_COUNT_OUT_EN
        ,
        .OUT_COUNT (OUT_COUNT)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_count(input string tag, input logic [3:0] exp);
`ifdef CELL_UPDATE_COUNT_OUT_EN
        check(tag, {4'b0, OUT_COUNT}, {4'b0, exp});
`endif
    endtask

    // Called at a falling edge, and returns at the falling edge right after
    // the rising edge that accepted the beat. With gap > 0, IN_VALID stays
    // low for that many idle cycles before the beat is presented.
    task automatic beat(input logic b, input int gap);
        int n;
        IN_VALID = 1'b0;
        repeat (gap) @(negedge CLK);
        n = 0;
        IN_VALID = 1'b1;
        IN_BIT   = b;
        while (IN_READY !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("in_ready_wait", {7'b0, IN_READY}, 8'h01);
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic send_cell(input logic [7:0] nb, input logic self_b, input int max_gap);
        for (int i = 0; i < 8; i++) beat(nb[i], $urandom_range(max_gap, 0));
        beat(self_b, $urandom_range(max_gap, 0));
    endtask

    // The result is checked in the cycle it appears, then taken with
    // OUT_READY=1 (the caller set it).
    task automatic check_result(input string tag, input logic alive, input logic [3:0] cnt);
        check({tag, "_valid"}, {7'b0, OUT_VALID}, 8'h01);
        check({tag, "_ready_low"}, {7'b0, IN_READY}, 8'h00);
        check({tag, "_alive"}, {7'b0, OUT_ALIVE}, {7'b0, alive});
        check_count({tag, "_count"}, cnt);
        @(negedge CLK);
        check({tag, "_valid_drop"}, {7'b0, OUT_VALID}, 8'h00);
        check({tag, "_ready_back"}, {7'b0, IN_READY}, 8'h01);
    endtask

    initial begin
        RESET     = 1'b1;
        IN_VALID  = 1'b0;
        IN_BIT    = 1'b0;
        OUT_READY = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_in_ready", {7'b0, IN_READY}, 8'h00);
        check("rst_out_valid", {7'b0, OUT_VALID}, 8'h00);
        check("rst_out_alive", {7'b0, OUT_ALIVE}, 8'h00);
        check_count("rst_count", 4'd0);

        RESET = 1'b0;
        @(negedge CLK);
        check("ready_after_rst", {7'b0, IN_READY}, 8'h01);

        // Three live neighbours, dead cell: a birth. The result appears after 9 edges.
        start = cyc;
        send_cell(8'b0000_0111, 1'b0, 0);
        check("latency_9", 8'(cyc - start), 8'd9);
        check_result("birth3", 1'b1, 4'd3);

        // Two live neighbours: the cell survives only if it is alive.
        send_cell(8'b0010_1000, 1'b1, 0);
        check_result("survive2", 1'b1, 4'd2);
        send_cell(8'b0010_1000, 1'b0, 0);
        check_result("dead2", 1'b0, 4'd2);

        // Extremes: count of 8 must not wrap, and count of 0.
        send_cell(8'hFF, 1'b1, 0);
        check_result("full8", 1'b0, 4'd8);
        send_cell(8'h00, 1'b0, 0);
        check_result("empty0", 1'b0, 4'd0);

        // Backpressure: hold the result for 5 cycles while upstream pushes beats.
        OUT_READY = 1'b0;
        send_cell(8'b1001_0001, 1'b0, 0);
        IN_VALID = 1'b1;
        IN_BIT   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {7'b0, OUT_VALID}, 8'h01);
            check("hold_alive", {7'b0, OUT_ALIVE}, 8'h01);
            check("hold_ready", {7'b0, IN_READY}, 8'h00);
            check_count("hold_count", 4'd3);
            @(negedge CLK);
        end
        OUT_READY = 1'b1;
        IN_VALID  = 1'b0;
        @(negedge CLK);
        check("release_ready", {7'b0, IN_READY}, 8'h01);
        check("release_valid", {7'b0, OUT_VALID}, 8'h00);
        // The beats pushed during HOLD must not have been counted.
        send_cell(8'h00, 1'b1, 0);
        check_result("after_hold", 1'b0, 4'd0);

        // IN_VALID with random idle gaps: the same result as a continuous feed.
        send_cell(8'b0100_0110, 1'b1, 3);
        check_result("gappy3", 1'b1, 4'd3);
        send_cell(8'b0100_0110, 1'b1, 0);
        check_result("cont3", 1'b1, 4'd3);

        // Reset after five beats, then a clean 2-live dead cell.
        for (int i = 0; i < 5; i++) beat(1'b1, 0);
        RESET = 1'b1;
        #1;
        check("midrst_ready", {7'b0, IN_READY}, 8'h00);
        check("midrst_valid", {7'b0, OUT_VALID}, 8'h00);
        check("midrst_alive", {7'b0, OUT_ALIVE}, 8'h00);
        check_count("midrst_count", 4'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("midrst_ready_back", {7'b0, IN_READY}, 8'h01);
        send_cell(8'b0010_0100, 1'b0, 0);
        check_result("post_rst2", 1'b0, 4'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
